// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: 2-entry skid buffer between the ALU and writeback,
// with combinational forwarding of buffered results and a sticky overflow flag.
module ex_result_stage #(
  parameter int WIDTH = 16,
  parameter int RW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_z,
  input  logic             in_ofl,
  input  logic             in_wr_en,
  input  logic [RW-1:0]    in_wr_reg,
  input  logic             in_trap_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_wr_en,
  output logic [RW-1:0]    out_wr_reg,
  output logic             out_exc,
  input  logic [RW-1:0]    fwd_reg,
  output logic             fwd_hit,
  output logic [WIDTH-1:0] fwd_data,
  output logic             ofl_sticky,
  input  logic             ofl_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             z;
    logic             wr_en;
    logic [RW-1:0]    wr_reg;
    logic             exc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, new_e;
  logic   sticky_q, sticky_d;
  logic   head_vld, skid_vld, accept, pop;
  logic   hit_head, hit_skid;

  // Entry valids are implied by occupancy.
  assign head_vld = (state_q != EMPTY);
  assign skid_vld = (state_q == TWO);
  assign in_ready = ~skid_vld;
  assign accept   = in_valid & in_ready;
  assign pop      = head_vld & out_ready;

  // Trapping overflow suppresses the register write.
  always_comb begin
    new_e        = '0;
    new_e.result = in_result;
    new_e.z      = in_z;
    new_e.exc    = in_ofl & in_trap_en;
    new_e.wr_en  = in_wr_en & ~(in_ofl & in_trap_en);
    new_e.wr_reg = in_wr_reg;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          head_d  = new_e;
        end
        ONE: begin
          if (accept && !pop) begin
            state_d = TWO;
            skid_d  = new_e;
          end else if (accept && pop) begin
            head_d = new_e;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (ofl_clr)           sticky_d = 1'b0;
    if (accept && in_ofl)  sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = head_vld;
  assign out_result = head_vld ? head_q.result : '0;
  assign out_z      = head_vld & head_q.z;
  assign out_wr_en  = head_vld & head_q.wr_en;
  assign out_wr_reg = head_vld ? head_q.wr_reg : '0;
  assign out_exc    = head_vld & head_q.exc;
  assign ofl_sticky = sticky_q;

  // SKID holds the younger instruction, so it wins the forward.
  assign hit_head = head_vld & head_q.wr_en & (head_q.wr_reg == fwd_reg);
  assign hit_skid = skid_vld & skid_q.wr_en & (skid_q.wr_reg == fwd_reg);
  assign fwd_hit  = hit_head | hit_skid;
  assign fwd_data = hit_skid ? skid_q.result :
                    hit_head ? head_q.result : '0;

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: capture vector table, scoreboard on the output
// handshake, and hand-written backpressure/forward/flush/stream/reset sequences.
module tb_ex_result_stage;
  localparam int WIDTH = 16;
  localparam int RW    = 3;

  logic             clk, rst;
  logic             in_valid, in_ready, in_z, in_ofl, in_wr_en, in_trap_en, flush;
  logic [WIDTH-1:0] in_result, out_result, fwd_data;
  logic [RW-1:0]    in_wr_reg, out_wr_reg, fwd_reg;
  logic             out_valid, out_ready, out_z, out_wr_en, out_exc;
  logic             fwd_hit, ofl_sticky, ofl_clr;

  ex_result_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_z(in_z), .in_ofl(in_ofl), .in_wr_en(in_wr_en), .in_wr_reg(in_wr_reg),
    .in_trap_en(in_trap_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_z(out_z), .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg), .out_exc(out_exc),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ofl_sticky(ofl_sticky), .ofl_clr(ofl_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [WIDTH+RW+2:0] exp_t;  // {result, z, wr_en, wr_reg, exc}
  exp_t q[$];
  int   n_chk, n_fail;

  typedef struct {
    logic [15:0] res;
    logic        z, ofl, wr, trap;
    logic [2:0]  rg;
    logic        e_wr, e_exc, e_hit;
    logic [15:0] e_fwd;
    logic        e_st;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Sampled mid-cycle: compares the popped head, then records a new accept.
  task automatic sb_sample();
    exp_t e;
    if (flush) begin
      q.delete();
      return;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_spurious: got result %h expected no output @%0t", out_result, $time);
      end else begin
        e = q.pop_front();
        check("sb_head", 32'({out_result, out_z, out_wr_en, out_wr_reg, out_exc}), 32'(e));
      end
    end
    if (in_valid && in_ready)
      q.push_back({in_result, in_z, in_wr_en & ~(in_ofl & in_trap_en), in_wr_reg,
                   in_ofl & in_trap_en});
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] r, input logic [2:0] rg, input logic ofl, input logic trap);
    in_valid = 1'b1; in_result = r; in_wr_reg = rg; in_wr_en = 1'b1;
    in_z = (r == 16'h0); in_ofl = ofl; in_trap_en = trap;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    vt[0] = '{16'h1234, 0, 0, 1, 0, 3'd3, 1, 0, 1, 16'h1234, 0};
    vt[1] = '{16'h0000, 1, 0, 1, 1, 3'd0, 1, 0, 1, 16'h0000, 0};
    vt[2] = '{16'h8000, 0, 1, 1, 1, 3'd5, 0, 1, 0, 16'h0000, 1};
    vt[3] = '{16'h7FFF, 0, 1, 1, 0, 3'd6, 1, 0, 1, 16'h7FFF, 1};
    vt[4] = '{16'hABCD, 0, 0, 0, 0, 3'd7, 0, 0, 0, 16'h0000, 0};
    vt[5] = '{16'hFFFF, 0, 1, 0, 1, 3'd2, 0, 1, 0, 16'h0000, 1};

    rst = 1'b1; in_valid = 0; in_result = 0; in_z = 0; in_ofl = 0; in_wr_en = 0;
    in_wr_reg = 0; in_trap_en = 0; flush = 0; out_ready = 0; fwd_reg = 0; ofl_clr = 0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_sticky", ofl_sticky, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single captures from EMPTY, sticky cleared between vectors.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_result = vt[i].res; in_z = vt[i].z; in_ofl = vt[i].ofl;
      in_wr_en = vt[i].wr; in_trap_en = vt[i].trap; in_wr_reg = vt[i].rg;
      fwd_reg = vt[i].rg; out_ready = 0;
      step();
      in_valid = 0;
      check("v_out_valid", out_valid, 1);
      check("v_out_result", out_result, vt[i].res);
      check("v_out_z", out_z, vt[i].z);
      check("v_out_wr_en", out_wr_en, vt[i].e_wr);
      check("v_out_wr_reg", out_wr_reg, vt[i].rg);
      check("v_out_exc", out_exc, vt[i].e_exc);
      check("v_fwd_hit", fwd_hit, vt[i].e_hit);
      check("v_fwd_data", fwd_data, vt[i].e_fwd);
      check("v_sticky", ofl_sticky, vt[i].e_st);
      out_ready = 1; ofl_clr = 1;
      step();
      out_ready = 0; ofl_clr = 0;
      check("v_drained", out_valid, 0);
      check("v_sticky_clr", ofl_sticky, 0);
    end

    // Backpressure: fill both entries, refuse a third, drain in order.
    push(16'h0001, 3'd1, 0, 0); step();
    check("bp_ready_one", in_ready, 1);
    push(16'h0002, 3'd1, 0, 0); step();
    check("bp_ready_full", in_ready, 0);
    push(16'h0003, 3'd1, 0, 0); step();
    check("bp_ready_hold", in_ready, 0);
    check("bp_head_stable", out_result, 16'h0001);
    in_valid = 0; out_ready = 1; step();
    check("bp_second", out_result, 16'h0002);
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_empty", out_valid, 0);
    out_ready = 0;

    // Exception entry plus sticky set/clear races.
    push(16'h1111, 3'd4, 1, 1); fwd_reg = 3'd4; step();
    in_valid = 0;
    check("exc_out_exc", out_exc, 1);
    check("exc_out_wr_en", out_wr_en, 0);
    check("exc_fwd_hit", fwd_hit, 0);
    check("exc_sticky", ofl_sticky, 1);
    push(16'h2222, 3'd6, 1, 0); ofl_clr = 1; step();
    in_valid = 0;
    check("exc_set_wins", ofl_sticky, 1);
    step();
    check("exc_clr", ofl_sticky, 0);
    ofl_clr = 0; out_ready = 1; step(); step();
    check("exc_drained", out_valid, 0);
    out_ready = 0;

    // Youngest-match forwarding, then flush from TWO.
    push(16'hAAAA, 3'd5, 1, 0); step();
    push(16'h5555, 3'd5, 0, 0); step();
    in_valid = 0; fwd_reg = 3'd5; #1;
    check("fwd_young", fwd_data, 16'h5555);
    check("fwd_hit2", fwd_hit, 1);
    check("fwd_sticky", ofl_sticky, 1);
    fwd_reg = 3'd4; #1;
    check("fwd_miss_hit", fwd_hit, 0);
    check("fwd_miss_data", fwd_data, 0);
    fwd_reg = 3'd5;
    push(16'h9999, 3'd5, 1, 0); flush = 1; out_ready = 1; step();
    flush = 0; in_valid = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_fwd_hit", fwd_hit, 0);
    check("fl_sticky", ofl_sticky, 1);
    step();
    check("fl_nothing", out_valid, 0);

    // Full-rate stream.
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      push(16'(i), 3'd1, 0, 0); step();
      check("st_valid", out_valid, 1);
      check("st_result", out_result, 32'(i));
    end
    in_valid = 0; step();
    check("st_done", out_valid, 0);

    // Asynchronous reset in the middle of a stream.
    fwd_reg = 3'd1;
    for (int i = 0; i < 3; i++) begin
      push(16'h0100 + 16'(i), 3'd1, 1, 0); step();
    end
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_fwd_hit", fwd_hit, 0);
    check("ar_sticky", ofl_sticky, 0);
    q.delete(); in_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("ar_after", out_valid, 0);
    check("sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Execute-stage output buffer that sits directly downstream of the 16-bit ALU.
- Captures the ALU result, zero flag, overflow flag and destination-register tag into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Presents entries in order to the memory/writeback stage.
- Also provides combinational forwarding of buffered results back to operand selection, and maintains a sticky overflow status bit.

Parameters:
- WIDTH, 16, data width of ALU result
- RW, 3, register index width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU side presents a result this cycle
- in_ready  output  1  stage can accept this cycle
- in_result  input  WIDTH  ALU Out
- in_z  input  1  ALU zero flag
- in_ofl  input  1  ALU overflow flag
- in_wr_en  input  1  instruction writes a register
- in_wr_reg  input  RW  destination register index
- in_trap_en  input  1  overflow on this instruction raises exception
- flush  input  1  discard all buffered entries
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_result  output  WIDTH  head result
- out_z  output  1  head zero flag
- out_wr_en  output  1  head register-write enable (already qualified by exception)
- out_wr_reg  output  RW  head destination index
- out_exc  output  1  head entry carries overflow exception
- fwd_reg  input  RW  register index being looked up
- fwd_hit  output  1  a buffered entry will write fwd_reg
- fwd_data  output  WIDTH  youngest matching buffered result
- ofl_sticky  output  1  sticky overflow status
- ofl_clr  input  1  clear sticky overflow

Behaviour:
- Reset (async, rst=1):
  - Both entries invalid.
  - All out_* = 0, fwd_hit=0, fwd_data=0, ofl_sticky=0.
  - in_ready=1 while and after reset.
- Storage is two entries, HEAD and SKID. Each entry holds: valid, result, z, wr_en, wr_reg, exc.
- Exception qualification on capture:
  - exc = in_ofl & in_trap_en.
  - stored wr_en = in_wr_en & ~exc.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = ~SKID.valid, a function of state only; it never depends on in_valid or out_ready.
  - out_valid = HEAD.valid; out_* are driven from HEAD fields.
- State machine, by occupancy:
  - EMPTY: accept -> ONE, data to HEAD.
  - ONE:
    - accept & ~pop -> TWO, data to SKID.
    - accept & pop -> ONE, HEAD loads new data.
    - pop only -> EMPTY.
    - neither -> hold.
  - TWO (in_ready=0):
    - pop -> ONE, HEAD <= SKID, SKID invalid.
    - otherwise hold.
- Latency and throughput:
  - Data accepted at edge N is visible on out_* after edge N when the buffer was EMPTY, or after HEAD pops otherwise.
  - Sustained throughput is 1 per cycle when out_ready=1.
- Output stability: out_* must hold stable while out_valid=1 & out_ready=0.
- flush (synchronous, highest priority):
  - Next edge both entries become invalid.
  - The accept and pop in that cycle are ignored; no entry is captured.
  - in_ready=1 the following cycle.
  - ofl_sticky is unaffected by flush.
- Forwarding (combinational, no latency):
  - An entry matches if valid & wr_en & (wr_reg == fwd_reg).
  - SKID is younger than HEAD and has priority.
  - fwd_hit = any match; fwd_data = result of the youngest match, else 0.
  - Exception entries never match, because their wr_en is cleared.
- Sticky overflow:
  - Set at an edge where accept & in_ofl, regardless of in_trap_en.
  - ofl_clr clears it.
  - Simultaneous set and ofl_clr: set wins, result 1.
- Reset asserted mid-operation drops all entries immediately. No partial state survives.

Test Plan:
- Reset, then single accept of in_result=16'h1234, in_wr_reg=3, in_wr_en=1 with out_ready=1 -> out_valid=1 next cycle, out_result=16'h1234, out_wr_reg=3; fwd_reg=3 -> fwd_hit=1, fwd_data=16'h1234.
- Hold out_ready=0 and push 16'h0001, then 16'h0002 -> in_ready=0 after the second push, and a third push is not accepted. Raise out_ready -> out_result sequence is 0001, 0002, with no loss or duplication.
- Both entries write reg 5 (HEAD=16'hAAAA, SKID=16'h5555), fwd_reg=5 -> fwd_data=16'h5555.
- Push with in_ofl=1, in_trap_en=1, in_wr_en=1 -> out_exc=1, out_wr_en=0, fwd_hit=0 for that reg, ofl_sticky=1. Then assert ofl_clr together with a new in_ofl=1 accept -> ofl_sticky stays 1.
- In TWO state, assert flush together with in_valid=1 -> out_valid=0 and in_ready=1 next cycle, nothing captured, ofl_sticky unchanged.
- Continuous in_valid and out_ready=1 for 8 results 0..7 -> out_result 0..7 on consecutive cycles. Assert rst mid-stream -> out_valid=0 immediately.
